// File: rtl/reg_wb_arbiter.sv
// Write-back arbiter for the register bank's single write port: one-entry ALU/LSU buffers,
// age-ordered issue with round-robin tie-break. Define WB_FWD_EN to add two forwarding lookups.
module reg_wb_arbiter #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             alu_vld,
  output logic             alu_rdy,
  input  logic [AW-1:0]    alu_addr,
  input  logic [DW-1:0]    alu_data,
  input  logic             lsu_vld,
  output logic             lsu_rdy,
  input  logic [AW-1:0]    lsu_addr,
  input  logic [DW-1:0]    lsu_data,
  output logic             rb_wen_n,
  output logic [AW-1:0]    rb_addr,
  output logic [DW-1:0]    rb_data,
  output logic [31:0]      pend,
  output logic [CNT_W-1:0] wr_cnt
`ifdef WB_FWD_EN
  ,
  input  logic [AW-1:0]    fwd_addr_a,
  input  logic [AW-1:0]    fwd_addr_b,
  output logic             fwd_hit_a,
  output logic             fwd_hit_b,
  output logic [DW-1:0]    fwd_data_a,
  output logic [DW-1:0]    fwd_data_b
`endif
);

  typedef enum logic {SRC_ALU = 1'b0, SRC_LSU = 1'b1} src_e;

  logic             alu_full_q, alu_full_d, alu_age_q, alu_age_d;
  logic [AW-1:0]    alu_addr_q, alu_addr_d;
  logic [DW-1:0]    alu_data_q, alu_data_d;
  logic             lsu_full_q, lsu_full_d, lsu_age_q, lsu_age_d;
  logic [AW-1:0]    lsu_addr_q, lsu_addr_d;
  logic [DW-1:0]    lsu_data_q, lsu_data_d;
  logic             rb_wen_n_q, rb_wen_n_d;
  logic [AW-1:0]    rb_addr_q, rb_addr_d;
  logic [DW-1:0]    rb_data_q, rb_data_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  src_e             rr_last_q, rr_last_d;

  logic ages_eq, sel_alu, sel_lsu, alu_fill, lsu_fill;

  // Age 0 marks the older entry; equal ages mean a same-edge fill, broken by round-robin.
  always_comb begin
    ages_eq = (alu_age_q == lsu_age_q);
    sel_alu = alu_full_q & (~lsu_full_q | (~ages_eq & ~alu_age_q) |
                            (ages_eq & (rr_last_q == SRC_LSU)));
    sel_lsu = lsu_full_q & ~sel_alu;
  end

  assign alu_rdy  = ~alu_full_q | sel_alu;
  assign lsu_rdy  = ~lsu_full_q | sel_lsu;
  assign alu_fill = alu_vld & alu_rdy & (alu_addr != '0);
  assign lsu_fill = lsu_vld & lsu_rdy & (lsu_addr != '0);

  always_comb begin
    // NOTE: every variable gets a default first so no latch is inferred.
    alu_full_d = alu_full_q;
    alu_age_d  = alu_age_q;
    alu_addr_d = alu_addr_q;
    alu_data_d = alu_data_q;
    lsu_full_d = lsu_full_q;
    lsu_age_d  = lsu_age_q;
    lsu_addr_d = lsu_addr_q;
    lsu_data_d = lsu_data_q;
    rb_wen_n_d = 1'b1;
    rb_addr_d  = rb_addr_q;
    rb_data_d  = rb_data_q;
    wr_cnt_d   = wr_cnt_q;
    rr_last_d  = rr_last_q;

    if (sel_alu) begin
      alu_full_d = 1'b0;
      rb_wen_n_d = 1'b0;
      rb_addr_d  = alu_addr_q;
      rb_data_d  = alu_data_q;
      rr_last_d  = SRC_ALU;
      wr_cnt_d   = wr_cnt_q + CNT_W'(1);
    end else if (sel_lsu) begin
      lsu_full_d = 1'b0;
      rb_wen_n_d = 1'b0;
      rb_addr_d  = lsu_addr_q;
      rb_data_d  = lsu_data_q;
      rr_last_d  = SRC_LSU;
      wr_cnt_d   = wr_cnt_q + CNT_W'(1);
    end

    // A fill is younger than the other buffer only if that one stays behind this cycle.
    if (alu_fill) begin
      alu_full_d = 1'b1;
      alu_addr_d = alu_addr;
      alu_data_d = alu_data;
      alu_age_d  = lsu_full_q & ~sel_lsu;
    end
    if (lsu_fill) begin
      lsu_full_d = 1'b1;
      lsu_addr_d = lsu_addr;
      lsu_data_d = lsu_data;
      lsu_age_d  = alu_full_q & ~sel_alu;
    end
  end

  // NOTE: payload registers are reset too, so rb_addr/rb_data read 0 after reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      alu_full_q <= 1'b0;
      alu_age_q  <= 1'b0;
      alu_addr_q <= '0;
      alu_data_q <= '0;
      lsu_full_q <= 1'b0;
      lsu_age_q  <= 1'b0;
      lsu_addr_q <= '0;
      lsu_data_q <= '0;
      rb_wen_n_q <= 1'b1;
      rb_addr_q  <= '0;
      rb_data_q  <= '0;
      wr_cnt_q   <= '0;
      rr_last_q  <= SRC_LSU;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      alu_full_q <= alu_full_d;
      alu_age_q  <= alu_age_d;
      alu_addr_q <= alu_addr_d;
      alu_data_q <= alu_data_d;
      lsu_full_q <= lsu_full_d;
      lsu_age_q  <= lsu_age_d;
      lsu_addr_q <= lsu_addr_d;
      lsu_data_q <= lsu_data_d;
      rb_wen_n_q <= rb_wen_n_d;
      rb_addr_q  <= rb_addr_d;
      rb_data_q  <= rb_data_d;
      wr_cnt_q   <= wr_cnt_d;
      rr_last_q  <= rr_last_d;
    end
  end

  assign rb_wen_n = rb_wen_n_q;
  assign rb_addr  = rb_addr_q;
  assign rb_data  = rb_data_q;
  assign wr_cnt   = wr_cnt_q;

  always_comb begin
    pend = '0;
    for (int i = 1; i < 32; i++) begin
      pend[i] = (alu_full_q && alu_addr_q == AW'(i)) ||
                (lsu_full_q && lsu_addr_q == AW'(i)) ||
                (!rb_wen_n_q && rb_addr_q == AW'(i));
    end
  end

`ifdef WB_FWD_EN
  // Returns {hit, data}; when both buffers match, the unselected one is the younger.
  function automatic logic [DW:0] fwd_lookup(input logic [AW-1:0] a);
    logic alu_m, lsu_m, iss_m;
    alu_m = alu_full_q && (alu_addr_q == a);
    lsu_m = lsu_full_q && (lsu_addr_q == a);
    iss_m = !rb_wen_n_q && (rb_addr_q == a);
    fwd_lookup = '0;
    if (a != '0) begin
      if (alu_m && lsu_m) fwd_lookup = {1'b1, sel_alu ? lsu_data_q : alu_data_q};
      else if (alu_m)     fwd_lookup = {1'b1, alu_data_q};
      else if (lsu_m)     fwd_lookup = {1'b1, lsu_data_q};
      else if (iss_m)     fwd_lookup = {1'b1, rb_data_q};
    end
  endfunction

  always_comb {fwd_hit_a, fwd_data_a} = fwd_lookup(fwd_addr_a);
  always_comb {fwd_hit_b, fwd_data_b} = fwd_lookup(fwd_addr_b);
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: directed scenarios plus random traffic against an oldest-first
// queue model; issued writes are checked by a scoreboard monitor on the falling edge.
module tb_reg_wb_arbiter;
  localparam int DW = 32, AW = 5, CNT_W = 16;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             alu_vld = 1'b0, lsu_vld = 1'b0;
  logic             alu_rdy, lsu_rdy;
  logic [AW-1:0]    alu_addr = '0, lsu_addr = '0;
  logic [DW-1:0]    alu_data = '0, lsu_data = '0;
  logic             rb_wen_n;
  logic [AW-1:0]    rb_addr;
  logic [DW-1:0]    rb_data;
  logic [31:0]      pend;
  logic [CNT_W-1:0] wr_cnt;
`ifdef WB_FWD_EN
  logic [AW-1:0]    fwd_addr_a = '0, fwd_addr_b = '0;
  logic             fwd_hit_a, fwd_hit_b;
  logic [DW-1:0]    fwd_data_a, fwd_data_b;
`endif

  always #5 clk = ~clk;

  reg_wb_arbiter #(.DW(DW), .AW(AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn),
    .alu_vld(alu_vld), .alu_rdy(alu_rdy), .alu_addr(alu_addr), .alu_data(alu_data),
    .lsu_vld(lsu_vld), .lsu_rdy(lsu_rdy), .lsu_addr(lsu_addr), .lsu_data(lsu_data),
    .rb_wen_n(rb_wen_n), .rb_addr(rb_addr), .rb_data(rb_data), .pend(pend), .wr_cnt(wr_cnt)
`ifdef WB_FWD_EN
    , .fwd_addr_a(fwd_addr_a), .fwd_addr_b(fwd_addr_b), .fwd_hit_a(fwd_hit_a),
    .fwd_hit_b(fwd_hit_b), .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b)
`endif
  );

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each source holds at most one request stamped with its acceptance cycle;
  // the oldest stamp issues next, same-cycle stamps alternate by the last issuing source.
  typedef struct {logic [AW-1:0] addr; logic [DW-1:0] data; int stamp;} ent_t;
  typedef struct {logic [AW-1:0] addr; logic [DW-1:0] data;} wr_t;

  wr_t           exp_q[$];
  wr_t           w;
  bit            m_full[2];
  ent_t          m_ent[2];
  int            m_rr_last, m_cnt, m_cycle, sel;
  bit            m_if_vld;
  logic [AW-1:0] m_if_addr;
  bit            mrdy[2], vv[2];
  logic [AW-1:0] va[2];
  logic [DW-1:0] vd[2];
  logic [31:0]   ep;

  task automatic model_clear();
    m_full[0] = 0; m_full[1] = 0;
    m_rr_last = 1;
    m_if_vld  = 0;
    m_if_addr = '0;
    m_cnt     = 0;
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    if (!rstn) model_clear();
    else begin
      ep = '0;
      for (int s = 0; s < 2; s++) if (m_full[s]) ep[m_ent[s].addr] = 1'b1;
      if (m_if_vld) ep[m_if_addr] = 1'b1;
      ep[0] = 1'b0;
      check("pend", pend, ep);
      check("rb_wen_n", rb_wen_n, !m_if_vld);
      check("wr_cnt", wr_cnt, m_cnt[15:0]);

      if (m_full[0] && m_full[1]) begin
        if (m_ent[0].stamp != m_ent[1].stamp) sel = (m_ent[0].stamp < m_ent[1].stamp) ? 0 : 1;
        else sel = 1 - m_rr_last;
      end else if (m_full[0]) sel = 0;
      else if (m_full[1]) sel = 1;
      else sel = -1;
      mrdy[0] = !m_full[0] || sel == 0;
      mrdy[1] = !m_full[1] || sel == 1;
      check("alu_rdy", alu_rdy, mrdy[0]);
      check("lsu_rdy", lsu_rdy, mrdy[1]);

      vv[0] = alu_vld; va[0] = alu_addr; vd[0] = alu_data;
      vv[1] = lsu_vld; va[1] = lsu_addr; vd[1] = lsu_data;
      if (sel >= 0) begin
        exp_q.push_back('{addr: m_ent[sel].addr, data: m_ent[sel].data});
        m_if_vld  = 1;
        m_if_addr = m_ent[sel].addr;
        m_cnt++;
        m_rr_last = sel;
        m_full[sel] = 0;
      end else m_if_vld = 0;
      for (int s = 0; s < 2; s++) begin
        if (vv[s] && mrdy[s] && va[s] != '0) begin
          m_full[s] = 1;
          m_ent[s]  = '{addr: va[s], data: vd[s], stamp: m_cycle};
        end
      end
      m_cycle++;
    end
  end

  // Scoreboard monitor: every bank write must match the next expected write.
  always @(negedge clk) begin
    if (rstn && rb_wen_n === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none", rb_addr, rb_data);
      end else begin
        w = exp_q.pop_front();
        check("wr_addr", rb_addr, w.addr);
        check("wr_data", rb_data, w.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_vld = 1'b0;
    lsu_vld = 1'b0;
  endtask

  task automatic drive(input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input bit lv, input logic [AW-1:0] la, input logic [DW-1:0] ld);
    alu_vld = av; alu_addr = aa; alu_data = ad;
    lsu_vld = lv; lsu_addr = la; lsu_data = ld;
    step();
  endtask

  // Leaves both buffers holding r7: LSU 0xA older, ALU 0xB younger, r2 being issued.
  task automatic build_both7();
    drive(0, 0, 0, 1, 1, 32'h5);
    idle();
    step();
    drive(1, 2, 32'h1, 1, 7, 32'hA);
    drive(1, 7, 32'hB, 0, 0, 0);
    idle();
  endtask

  logic [15:0] cnt0;
  bit          a_acc, l_acc;
  int          ak, lk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    m_cycle = 0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    check("rst_wen_n", rb_wen_n, 1);
    check("rst_addr", rb_addr, 0);
    check("rst_data", rb_data, 0);
    check("rst_pend", pend, 0);
    check("rst_cnt", wr_cnt, 0);
    check("rst_alu_rdy", alu_rdy, 1);
    check("rst_lsu_rdy", lsu_rdy, 1);

    // Single request: issue visible exactly one cycle after acceptance.
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0);
    idle();
    check("t1_c1_wen", rb_wen_n, 1);
    check("t1_c1_pend5", pend[5], 1);
    step();
    check("t1_c2_wen", rb_wen_n, 0);
    check("t1_c2_addr", rb_addr, 5);
    check("t1_c2_data", rb_data, 32'hDEADBEEF);
    check("t1_c2_pend5", pend[5], 1);
    check("t1_c2_cnt", wr_cnt, 1);
    step();
    check("t1_c3_wen", rb_wen_n, 1);
    check("t1_c3_pend5", pend[5], 0);
    check("t1_c3_cnt", wr_cnt, 1);

    // Same-edge ties: first with rr_last=LSU, then with rr_last=ALU.
    drive(0, 0, 0, 1, 1, 32'h5);
    idle();
    step();
    drive(1, 3, 32'h11, 1, 4, 32'h22);
    idle();
    step();
    check("tie1_first", rb_addr, 3);
    step();
    check("tie1_second", rb_addr, 4);
    drive(1, 9, 32'h33, 0, 0, 0);
    drive(1, 3, 32'h44, 1, 4, 32'h55);
    idle();
    check("tie2_pre", rb_addr, 9);
    step();
    check("tie2_first", rb_data, 32'h55);
    step();
    check("tie2_second", rb_data, 32'h44);
    step();

    // Same address, staggered acceptance, then both buffers holding r7 at once.
    drive(0, 0, 0, 1, 7, 32'hA);
    drive(1, 7, 32'hB, 0, 0, 0);
    idle();
    check("age1_first", rb_data, 32'hA);
    step();
    check("age1_second", rb_data, 32'hB);
    build_both7();
    check("age2_issue", rb_addr, 2);
    step();
    check("age2_older", rb_data, 32'hA);
    step();
    check("age2_younger", rb_data, 32'hB);
    repeat (2) step();

    // r0 write: handshake completes, nothing is issued.
    cnt0 = m_cnt[15:0];
    alu_vld = 1; alu_addr = 0; alu_data = 32'hFFFFFFFF;
    check("r0_rdy", alu_rdy, 1);
    step();
    idle();
    check("r0_pend0", pend[0], 0);
    step();
    check("r0_wen", rb_wen_n, 1);
    check("r0_cnt", wr_cnt, cnt0);
    check("r0_pend", pend, 0);

    // Back-pressure: both sources stream; each request held until accepted.
    ak = 0; lk = 0;
    for (int i = 0; i < 10; i++) begin
      alu_vld = 1; alu_addr = AW'(8 + ak % 4);  alu_data = 32'hA000 + ak;
      lsu_vld = 1; lsu_addr = AW'(16 + lk % 4); lsu_data = 32'hB000 + lk;
      a_acc = alu_rdy; l_acc = lsu_rdy;
      step();
      if (a_acc) ak++;
      if (l_acc) lk++;
      if (i >= 1) begin
        check("bp_wen_low", rb_wen_n, 0);
        check("bp_rdy_alt", alu_rdy ^ lsu_rdy, 1);
      end
    end
    idle();
    repeat (3) step();

    // Random traffic, small address range for collisions and r0 hits.
    for (int i = 0; i < 400; i++) begin
      if (!alu_vld && $urandom_range(0, 99) < 60) begin
        alu_vld = 1; alu_addr = AW'($urandom_range(0, 7)); alu_data = $urandom;
        if (lsu_vld && alu_addr == lsu_addr && alu_addr != 0) alu_addr = alu_addr ^ 5'd8;
      end
      if (!lsu_vld && $urandom_range(0, 99) < 60) begin
        lsu_vld = 1; lsu_addr = AW'($urandom_range(0, 7)); lsu_data = $urandom;
        if (alu_vld && lsu_addr == alu_addr && lsu_addr != 0) lsu_addr = lsu_addr ^ 5'd8;
      end
      a_acc = alu_vld & alu_rdy;
      l_acc = lsu_vld & lsu_rdy;
      step();
      if (a_acc) alu_vld = 0;
      if (l_acc) lsu_vld = 0;
    end
    idle();
    repeat (4) step();
    check("drain_empty", exp_q.size(), 0);

    // Mid-operation reset with both buffers full.
    build_both7();
`ifdef WB_FWD_EN
    fwd_addr_a = 7; fwd_addr_b = 2;
    #1;
    check("fwd_a_hit", fwd_hit_a, 1);
    check("fwd_a_data", fwd_data_a, 32'hB);
    check("fwd_b_hit", fwd_hit_b, 1);
    check("fwd_b_data", fwd_data_b, 32'h1);
    fwd_addr_b = 0;
    #1;
    check("fwd_b_r0", fwd_hit_b, 0);
`endif
    rstn = 1'b0;
    #1;
    check("mrst_wen", rb_wen_n, 1);
    check("mrst_pend", pend, 0);
    check("mrst_cnt", wr_cnt, 0);
    check("mrst_alu_rdy", alu_rdy, 1);
    check("mrst_lsu_rdy", lsu_rdy, 1);
    @(posedge clk);
    #1 rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_wen", rb_wen_n, 1);
    end
    check("post_rst_cnt", wr_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
- Write-back arbiter and scheduler for the single write port of the core's 32x32 register bank.
- Accepts write-back requests from two producers, ALU and LSU, over valid/ready handshakes and buffers one request per source.
- Issues at most one write per cycle to the bank's active-low write port, in age order.
- Publishes a pending-write bitmap for hazard detection in decode.

Parameters:
- DW, 32, data width of a write-back
- AW, 5, register address width (32 registers; r0 hardwired zero)
- CNT_W, 16, width of the issued-write statistics counter

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous reset, active-low
- alu_vld  input  1  ALU write-back request valid
- alu_rdy  output  1  ALU buffer can accept this cycle
- alu_addr  input  AW  ALU destination register
- alu_data  input  DW  ALU result
- lsu_vld  input  1  LSU write-back request valid
- lsu_rdy  output  1  LSU buffer can accept this cycle
- lsu_addr  input  AW  LSU destination register
- lsu_data  input  DW  load data
- rb_wen_n  output  1  register bank write enable, active-low, registered
- rb_addr  output  AW  register bank write address, registered
- rb_data  output  DW  register bank write data, registered
- pend  output  32  bit i = 1 while a write to register i is buffered or being issued
- wr_cnt  output  CNT_W  count of issued writes, wraps
- fwd_addr_a, fwd_addr_b  input  AW  forward lookup addresses (WB_FWD_EN only)
- fwd_hit_a, fwd_hit_b  output  1  lookup hit (WB_FWD_EN only)
- fwd_data_a, fwd_data_b  output  DW  forwarded data (WB_FWD_EN only)

Behaviour:
- State:
  - Per source: one-entry buffer {full, addr, data, age}.
  - One issue register {rb_wen_n, rb_addr, rb_data}.
  - A round-robin pointer, rr_last.
- Reset values:
  - Buffers empty; rb_wen_n=1; rb_addr=0; rb_data=0; wr_cnt=0.
  - rr_last=LSU, so the ALU wins the first tie.
  - pend=0; alu_rdy=lsu_rdy=1.
- Accept rule:
  - src_rdy = !buf_full | (buf selected for issue this cycle). This is combinational, and rdy must not depend on vld.
  - A transfer occurs on vld & rdy.
- Write to addr 0: the request is accepted (handshake completes), discarded, and the buffer is not filled.
- Age:
  - On fill, a buffer's age is set to 1 if the other buffer is already full and not issuing this cycle; otherwise it is 0.
  - A buffer that remains full keeps its age.
- Arbitration each cycle, among full buffers:
  - If exactly one is full, it is selected.
  - If both are full and ages differ, the buffer with age 0 (older) is selected.
  - If both are full and ages are equal (filled on the same edge), round-robin applies: the source not equal to rr_last is selected. rr_last updates on every issue.
- Issue:
  - At the edge after selection: rb_wen_n<=0, rb_addr/rb_data <= the buffer contents, the buffer is freed, and wr_cnt increments (wraps at 2^CNT_W).
  - With no selection: rb_wen_n<=1; rb_addr/rb_data hold their values.
- Latency:
  - Accepted at edge N: rb_wen_n is low from edge N+1, and the bank captures at edge N+2.
  - Sustained throughput is 1 write/cycle. With both sources streaming, each gets 1 issue per 2 cycles.
- Ordering: two writes to the same address always reach the bank in acceptance order. Same-edge fills to the same address issue ALU first only if rr_last=LSU; producers must not issue same-cycle same-address writes.
- pend[i]: set when any full buffer has addr i, or when rb_wen_n=0 & rb_addr=i. pend[0] is always 0. pend is derived only from registered state.
- Reset asserted mid-operation: all buffered and in-flight writes are dropped. rb_wen_n goes to 1 asynchronously, and nothing is written afterwards.

Optional Feature:
- Macro WB_FWD_EN.
- When defined, for each lookup port x in {a, b}:
  - fwd_hit_x=1 if fwd_addr_x != 0 and matches a full buffer or the active issue register.
  - fwd_data_x is the youngest matching entry, with priority younger buffer > older buffer > issue register.
  - The lookup is purely combinational, with zero latency.
- When undefined: the fwd_* ports and logic are absent; consumers stall on pend.

Test Plan:
- Reset, then single request: ALU vld with addr=5, data=0xDEADBEEF at edge 1 -> rb_wen_n=0, rb_addr=5, rb_data=0xDEADBEEF during cycle 2 only; pend[5]=1 for cycles 1-2, then 0; wr_cnt=1.
- Same-edge tie: ALU (3, 0x11) and LSU (4, 0x22) accepted at the same edge after reset -> addr 3 issued first, then addr 4 on the next cycle; repeat -> LSU first.
- Age order: LSU (7, 0xA) accepted at edge 1, ALU (7, 0xB) at edge 2 while LSU still buffered -> the issue sequence is 0xA then 0xB.
- Back-pressure: both sources hold vld every cycle for 10 cycles -> rb_wen_n stays low continuously, grants alternate, and alu_rdy, lsu_rdy each drop on alternate cycles; no request is lost.
- r0 write: ALU addr=0, data=0xFFFFFFFF -> alu_rdy=1, no issue (rb_wen_n stays 1), pend[0]=0, wr_cnt unchanged.
- Mid-op reset: both buffers full, rstn low for 1 cycle -> rb_wen_n=1 immediately, pend=0, wr_cnt=0, and no write after release. Under WB_FWD_EN, before the reset: fwd_addr_a=7 with both buffers holding addr 7 -> fwd_hit_a=1 with the younger data.
